// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the instruction-fetch stage: program load, run control,
// pipeline control and the IF/ID output register.
interface instr_fetch_unit_if #(
  parameter int unsigned IW    = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned MAW = $clog2(DEPTH);

  logic           start;
  logic           prog_we;
  logic [MAW-1:0] prog_addr;
  logic [IW-1:0]  prog_data;
  logic           stall;
  logic           redirect_valid;
  logic [AW-1:0]  redirect_pc;
  logic [IW-1:0]  instr_out;
  logic [AW-1:0]  pc_out;
  logic           instr_valid;
  logic           halted;
  logic           busy;

  // Fetch unit side
  modport slave (
    input  start, prog_we, prog_addr, prog_data, stall, redirect_valid, redirect_pc,
    output instr_out, pc_out, instr_valid, halted, busy
  );

  // Controller / consumer side
  modport master (
    output start, prog_we, prog_addr, prog_data, stall, redirect_valid, redirect_pc,
    input  instr_out, pc_out, instr_valid, halted, busy
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: loadable instruction memory, PC with sequential /
// pseudo-direct jump / redirect selection, IF/ID register, IDLE/RUN/HALTED control.
module instr_fetch_unit #(
  parameter int unsigned    IW        = 8,
  parameter int unsigned    AW        = 8,
  parameter int unsigned    DEPTH     = 64,
  parameter int unsigned    JW        = 6,
  parameter logic [AW-1:0]  START_PC  = '0,
  parameter logic [IW-1:0]  HALT_CODE = IW'(8'hFF)
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.slave   bus
);
  localparam int unsigned MAW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [IW-1:0] mem [DEPTH];

  logic          in_range;
  logic [IW-1:0] fetched;
  logic          is_halt;
  logic          is_jump;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] next_pc;

  // Combinational fetch and next-PC selection; addresses past the memory read as NOP
  always_comb begin
    in_range = (pc_q >> MAW) == '0;
    fetched  = in_range ? mem[pc_q[MAW-1:0]] : '0;
    is_halt  = (fetched == HALT_CODE);
    is_jump  = fetched[IW-1];
    pc_inc   = pc_q + AW'(1);
    // Jump keeps the page bits of PC+1, replaces the low JW bits
    next_pc  = is_jump ? {pc_inc[AW-1:JW], fetched[JW-1:0]} : pc_inc;
  end

  // Program load port; only writable while idle, contents survive reset
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state_q == StIdle)) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Run-control FSM with PC and registered IF/ID outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      pc_q            <= START_PC;
      bus.instr_out   <= '0;
      bus.pc_out      <= '0;
      bus.instr_valid <= 1'b0;
      bus.halted      <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          bus.instr_valid <= 1'b0;
          if (bus.start) begin
            state_q  <= StRun;
            pc_q     <= START_PC;
            bus.busy <= 1'b1;
          end
        end
        StRun: begin
          if (bus.redirect_valid) begin
            // Redirect squashes the IF/ID register and wins over stall
            pc_q            <= bus.redirect_pc;
            bus.instr_valid <= 1'b0;
          end else if (!bus.stall) begin
            bus.instr_out   <= fetched;
            bus.pc_out      <= pc_q;
            bus.instr_valid <= 1'b1;
            if (is_halt) begin
              // Halt word is presented; PC stays on it
              state_q    <= StHalted;
              bus.halted <= 1'b1;
              bus.busy   <= 1'b0;
            end else begin
              pc_q <= next_pc;
            end
          end
        end
        StHalted: begin
          bus.instr_valid <= 1'b0;
          if (bus.redirect_valid) begin
            state_q    <= StRun;
            pc_q       <= bus.redirect_pc;
            bus.halted <= 1'b0;
            bus.busy   <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Parametrised instruction-fetch stage for the pipelined core. It holds a loadable instruction memory, a PC with sequential, pseudo-direct-jump and external-redirect next-PC selection, and an IF/ID output register with valid, stall and flush control. A small run-control FSM (IDLE/RUN/HALTED) gates fetching, so the program is loaded over a write port instead of being hard-coded at reset.

Parameters:
IW, 8, instruction width in bits (>= JW+2)
AW, 8, PC width in bits (> JW)
DEPTH, 64, instruction memory words (power of 2, <= 2**AW)
JW, 6, jump target field width: instr[JW-1:0]
START_PC, 0, PC value loaded at reset and on start
HALT_CODE, 8'hFF, instruction encoding that halts fetch (IW bits)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low
start  in  1  IDLE->RUN request
prog_we  in  1  program write strobe, honoured only in IDLE
prog_addr  in  $clog2(DEPTH)  program write address
prog_data  in  IW  program write data
stall  in  1  hold IF/ID register and PC
redirect_valid  in  1  flush and load PC from redirect_pc
redirect_pc  in  AW  redirect target
instr_out  out  IW  fetched instruction (IF/ID)
pc_out  out  AW  address of instr_out
instr_valid  out  1  instr_out/pc_out hold a live instruction
halted  out  1  FSM in HALTED
busy  out  1  FSM in RUN

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, PC=START_PC, instr_out=0, pc_out=0, instr_valid=0, halted=0, busy=0. Memory contents are not affected by reset.
- Memory read is combinational from PC. If PC >= DEPTH, the fetched word is 0 (NOP).
- Memory write is synchronous: mem[prog_addr] <= prog_data when prog_we=1 and state=IDLE. prog_we is ignored in RUN and HALTED.
- IDLE: no fetch, instr_valid=0. start=1 -> RUN next cycle with PC=START_PC.
- RUN, per cycle, in priority order:
  1. redirect_valid=1: PC <= redirect_pc; instr_valid <= 0 (squash). Redirect overrides stall.
  2. stall=1: PC, instr_out, pc_out and instr_valid all hold.
  3. Otherwise: instr_out <= fetched word, pc_out <= PC, instr_valid <= 1, and PC <= next_pc.
- next_pc selection:
  - Fetched word == HALT_CODE: PC holds; state -> HALTED. The halt word itself is presented with instr_valid=1. Halt is checked before the jump test.
  - Else fetched[IW-1]=1 (jump): next_pc = {PC_1[AW-1:JW], fetched[JW-1:0]}, where PC_1 = PC+1 mod 2**AW. Zero fetch bubble.
  - Else: next_pc = PC_1. Wraps 2**AW-1 -> 0.
- Fetch latency: instruction at PC appears on instr_out one clock after the fetching edge. One instruction per cycle at most.
- HALTED: instr_valid <= 0 on the first HALTED cycle; halted=1; start is ignored. redirect_valid=1 -> RUN with PC=redirect_pc. Only reset returns to IDLE.
- Simultaneous start and prog_we in IDLE: the write completes and the FSM moves to RUN.
- Reset asserted mid-RUN: immediate return to reset values. Program is retained, so start re-runs it from START_PC.
- busy=1 iff RUN; halted=1 iff HALTED. Both are registered outputs.

Test Plan:
1. Load 12,52,5A,C5,13,53,FF at addr 0..6 in IDLE, pulse start -> instr_out/pc_out sequence 12/0, 52/1, 5A/2, C5/3, 53/5 (13 skipped by jump), FF/6; then halted=1, instr_valid=0, PC stays 6.
2. Same program, stall=1 for 3 cycles while instr_out=5A -> instr_out, pc_out and instr_valid frozen for 3 cycles, then C5/3 follows. No instruction is lost or duplicated.
3. During RUN, redirect_valid=1 with redirect_pc=1 while stall=1 -> next cycle instr_valid=0, then 52/1, 5A/2, ... resumes.
4. DEPTH=256: mem[7F]=C3 with redirect to 7F -> pc_out 7F, then 83 (page bits 10 kept from PC_1=80). mem[FF]=01 -> pc_out FF then 00 (wrap).
5. DEPTH=64, redirect_pc=0x50 -> instr_out=00 with instr_valid=1, and PC increments to 0x51. prog_we in RUN with prog_addr=0 -> mem[0] unchanged, verified after reset and restart.
6. Assert reset asynchronously mid-RUN (between clock edges) -> outputs immediately at reset values, state IDLE. Pulse start -> program re-runs from START_PC with identical sequence.
